mmio_uart_ctrl: RTL and testbench

- Memory-mapped IO target for the 3-stage MIPS150 pipeline. Serves the IO address region, 0x8xxx_xxxx.
- Consumes the X-stage IO write byte-enables, ALU address and store data. Returns load data one cycle later, which the M stage uses as DataFromIO in place of the current dummy constant.
- Contains a UART transmitter, a UART receiver with a one-entry holding register, and status/counter registers.

---
 rtl/mmio_uart_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_mmio_uart_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_ctrl.sv
// mmio_uart_ctrl -- memory-mapped IO target for the MIPS150 IO region
// (addr[31:28] == 4'h8). Holds a UART transmitter, a UART receiver with a
// one-entry holding register, a status register and an optional free-running
// cycle counter.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset (0 = reset)
//   addr       X-stage byte address; addr[ADDR_MSB:2] selects the register
//   we         X-stage store byte-enables (big-endian: we[0] = bits 7:0)
//   wdata      X-stage store data
//   re         X-stage load to the IO region
//   rdata      registered load data, valid the cycle after re
//   serial_in  asynchronous UART RX line, idles high
//   serial_out UART TX line
//
// Register map (word offsets):
//   0x00 status  RO  {29'b0, rx_overrun, rx_valid, tx_ready}
//   0x04 rx_data RO  {24'b0, rx_byte}; reading clears rx_valid/rx_overrun
//   0x08 tx_data WO  we[0] launches wdata[7:0] when tx_ready
//   0x10 cycle_count RO, 0x14 counter_clear WO
//
// Optional feature macro: IO_CYCLE_COUNTER_EN. When undefined there are no
// counter flops, 0x10 reads 0 and writes to 0x14 are ignored.

module mmio_uart_ctrl #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_MSB     = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  input  logic        re,
  output logic [31:0] rdata,
  input  logic        serial_in,
  output logic        serial_out
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int OW = ADDR_MSB - 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [OW-1:0] OFF_STATUS = OW'(0);
  localparam logic [OW-1:0] OFF_RX     = OW'(1);
  localparam logic [OW-1:0] OFF_TX     = OW'(2);
`ifdef IO_CYCLE_COUNTER_EN
  localparam logic [OW-1:0] OFF_CYC    = OW'(4);
  localparam logic [OW-1:0] OFF_CLR    = OW'(5);
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_e;

  // ---------------- decode ----------------
  logic          io_hit, wr_any, rd_en, tx_launch, rx_rd_clr;
  logic [OW-1:0] off;
  logic          unused_bits;

  assign io_hit      = (addr[31:28] == 4'h8);
  assign off         = addr[ADDR_MSB:2];
  assign wr_any      = io_hit && (we != 4'b0000);
  assign rd_en       = io_hit && re;
  assign unused_bits = ^{addr[27:ADDR_MSB+1], addr[1:0], wdata[31:8]};

  // ---------------- state ----------------
  uart_st_e      tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_out_q, tx_out_d;

  logic          sync1_q, sync2_q;
  uart_st_e      rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_store;

  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ovr_q, rx_ovr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   rd_val;

`ifdef IO_CYCLE_COUNTER_EN
  logic [31:0]   cyc_q, cyc_d;
`endif

  assign tx_launch = wr_any && (off == OFF_TX) && we[0] && (tx_st_q == S_IDLE);
  assign rx_rd_clr = rd_en && (off == OFF_RX);

  // ---------------- TX FSM ----------------
  // serial_out is the registered tx_out_q, so each bit boundary is an edge.
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_idx_d = tx_idx_q;
    tx_sh_d  = tx_sh_q;
    tx_out_d = tx_out_q;
    case (tx_st_q)
      S_IDLE: begin
        if (tx_launch) begin
          tx_st_d  = S_START;
          tx_sh_d  = wdata[7:0];
          tx_cnt_d = '0;
          tx_out_d = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_st_d  = S_DATA;
          tx_cnt_d = '0;
          tx_idx_d = '0;
          tx_out_d = tx_sh_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_st_d  = S_STOP;
            tx_out_d = 1'b1;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_out_d = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: begin // S_STOP
        if (tx_cnt_q == BIT_LAST) begin
          tx_st_d  = S_IDLE;
          tx_cnt_d = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
    endcase
  end

  // ---------------- RX FSM ----------------
  // START re-samples at half a bit so DATA/STOP samples land mid-bit.
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_idx_d = rx_idx_q;
    rx_sh_d  = rx_sh_q;
    rx_store = 1'b0;
    case (rx_st_q)
      S_IDLE: begin
        if (!sync2_q) begin
          rx_st_d  = S_START;
          rx_cnt_d = '0;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_idx_d = '0;
          rx_st_d  = sync2_q ? S_IDLE : S_DATA; // high again: glitch
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {sync2_q, rx_sh_q[7:1]};
          if (rx_idx_q == 3'd7) rx_st_d = S_STOP;
          else                  rx_idx_d = rx_idx_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: begin // S_STOP
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_st_d  = S_IDLE;
          rx_store = sync2_q; // stop bit 0 = framing error, drop byte
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
    endcase
  end

  // ---------------- holding register / read mux / counter ----------------
  always_comb begin
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    if (rx_rd_clr) begin
      rx_valid_d = 1'b0;
      rx_ovr_d   = 1'b0;
    end
    // A byte landing on the read-clear edge wins; it is not an overrun
    // because the previous byte was consumed by that read.
    if (rx_store) begin
      rx_byte_d  = rx_sh_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_rd_clr) rx_ovr_d = 1'b1;
    end

    rd_val = '0;
    case (off)
      OFF_STATUS: rd_val = {29'b0, rx_ovr_q, rx_valid_q, (tx_st_q == S_IDLE)};
      OFF_RX:     rd_val = {24'b0, rx_byte_q};
`ifdef IO_CYCLE_COUNTER_EN
      OFF_CYC:    rd_val = cyc_q;
`endif
      default:    rd_val = '0;
    endcase
    rdata_d = rd_en ? rd_val : rdata_q;

`ifdef IO_CYCLE_COUNTER_EN
    cyc_d = (wr_any && (off == OFF_CLR)) ? '0 : cyc_q + 32'd1;
`endif
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_st_q    <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      tx_out_q   <= 1'b1;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_st_q    <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rdata_q    <= '0;
`ifdef IO_CYCLE_COUNTER_EN
      cyc_q      <= '0;
`endif
    end else begin
      tx_st_q    <= tx_st_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      tx_out_q   <= tx_out_d;
      sync1_q    <= serial_in;
      sync2_q    <= sync1_q;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rdata_q    <= rdata_d;
`ifdef IO_CYCLE_COUNTER_EN
      cyc_q      <= cyc_d;
`endif
    end
  end

  assign rdata      = rdata_q;
  assign serial_out = tx_out_q;

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed testbench for mmio_uart_ctrl with CLKS_PER_BIT = 8.
// Inputs change 1 time unit after a posedge; outputs are checked there too,
// so each check sees the result of the preceding edge.

module tb_mmio_uart_ctrl;
  localparam int CPB = 8;
  localparam logic [31:0] A_ST  = 32'h8000_0000;
  localparam logic [31:0] A_RX  = 32'h8000_0004;
  localparam logic [31:0] A_TX  = 32'h8000_0008;
  localparam logic [31:0] A_CYC = 32'h8000_0010;
  localparam logic [31:0] A_CLR = 32'h8000_0014;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  we = '0;
  logic [31:0] wdata = '0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic        serial_in = 1'b1;
  logic        serial_out;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mmio_uart_ctrl #(.CLKS_PER_BIT(CPB), .ADDR_MSB(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .we         (we),
    .wdata      (wdata),
    .re         (re),
    .rdata      (rdata),
    .serial_in  (serial_in),
    .serial_out (serial_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a);
    addr = a; re = 1'b1;
    tick();
    re = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; wdata = d; we = be;
    tick();
    we = '0;
  endtask

  // Expected line level k cycles after the launch edge.
  function automatic logic fbit(input logic [7:0] b, input int k);
    int s;
    s = k / CPB;
    if (s == 0) return 1'b0;
    if (s >= 9) return 1'b1;
    return b[s-1];
  endfunction

  // Called one unit after the launch edge. Optionally pokes a write while
  // busy; reads status in the last busy cycle (must still show not ready).
  task automatic tx_frame(input logic [7:0] b, input bit poke);
    for (int k = 0; k < 10*CPB; k++) begin
      chk($sformatf("tx_bit_k%0d", k), {31'b0, serial_out}, {31'b0, fbit(b, k)});
      if (poke && k == 20) begin addr = A_TX; wdata = 32'h0000_005A; we = 4'b0001; end
      if (k == 10*CPB-1) begin addr = A_ST; re = 1'b1; end
      tick();
      we = '0; re = 1'b0;
    end
    chk("tx_busy_last_cycle", rdata, 32'h0);
    chk("tx_line_idle", {31'b0, serial_out}, 32'h1);
  endtask

  task automatic send(input logic [7:0] b, input logic stopb);
    serial_in = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (CPB) tick();
    end
    serial_in = stopb;
    repeat (CPB) tick();
    serial_in = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- reset with a toggling RX line ----
    #1;
    for (int i = 0; i < 2; i++) begin
      serial_in = ~serial_in;
      tick();
    end
    chk("rst_serial_out", {31'b0, serial_out}, 32'h1);
    chk("rst_rdata", rdata, 32'h0);
    rst = 1'b1; serial_in = 1'b1;
    tick();
    chk("rdata_before_first_read", rdata, 32'h0);
    rd(A_ST);
    chk("status_after_reset", rdata, 32'h1);

    // ---- TX 0xA5 with a dropped write mid-frame ----
    wr(A_TX, 32'h0000_00A5, 4'b0001);
    tx_frame(8'hA5, 1'b1);
    // back-to-back launch in the first idle cycle
    wr(A_TX, 32'h0000_000F, 4'b0001);
    tx_frame(8'h0F, 1'b0);
    rd(A_ST);
    chk("status_tx_done", rdata, 32'h1);

    // ---- write outside the IO region is ignored ----
    wr(32'h0000_0008, 32'h0000_0000, 4'b0001);
    repeat (3) tick();
    chk("other_region_no_tx", {31'b0, serial_out}, 32'h1);

    // ---- RX single frame + read latency/hold ----
    send(8'h3C, 1'b1);
    repeat (4) tick();
    rd(A_ST);
    chk("rx_status_valid", rdata, 32'h3);
    addr = A_RX; re = 1'b1;
    chk("rd_before_edge", rdata, 32'h3);
    tick();
    re = 1'b0; addr = A_ST;
    chk("rx_data_3c", rdata, 32'h0000_003C);
    repeat (5) tick();
    chk("rdata_hold", rdata, 32'h0000_003C);
    rd(A_ST);
    chk("rx_status_cleared", rdata, 32'h1);

    // ---- RX overrun ----
    send(8'h81, 1'b1);
    send(8'h7E, 1'b1);
    repeat (4) tick();
    rd(A_ST);
    chk("rx_status_overrun", rdata, 32'h7);
    rd(A_RX);
    chk("rx_data_second", rdata, 32'h0000_007E);
    rd(A_ST);
    chk("rx_overrun_cleared", rdata, 32'h1);

    // ---- glitch rejection ----
    serial_in = 1'b0;
    repeat (3) tick();
    serial_in = 1'b1;
    repeat (20) tick();
    rd(A_ST);
    chk("rx_glitch", rdata, 32'h1);

    // ---- framing error ----
    send(8'h55, 1'b0);
    repeat (20) tick();
    rd(A_ST);
    chk("rx_framing", rdata, 32'h1);

    // ---- receiver recovers ----
    send(8'hC3, 1'b1);
    repeat (4) tick();
    rd(A_ST);
    chk("rx_recover_status", rdata, 32'h3);
    rd(A_RX);
    chk("rx_recover_data", rdata, 32'h0000_00C3);

    // ---- unmapped reads ----
    rd(32'h8000_000C);
    chk("unmapped_0c", rdata, 32'h0);
    rd(32'h8000_0020);
    chk("unmapped_20", rdata, 32'h0);

    // ---- cycle counter ----
`ifdef IO_CYCLE_COUNTER_EN
    wr(A_CLR, 32'h0000_0001, 4'b1111);
    repeat (100) tick();
    rd(A_CYC);
    chk("cyc_after_100", rdata, 32'd100);
    force dut.cyc_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_q;
    rd(A_CYC);
    chk("cyc_max", rdata, 32'hFFFF_FFFF);
    rd(A_CYC);
    chk("cyc_wrap", rdata, 32'h0);
`else
    rd(A_CYC);
    chk("cyc_off", rdata, 32'h0);
    wr(A_CLR, 32'h0000_0001, 4'b1111);
    rd(A_CYC);
    chk("cyc_off_after_clr", rdata, 32'h0);
`endif

    // ---- reset mid-frame ----
    wr(A_TX, 32'h0000_0000, 4'b0001);
    chk("mid_launch_low", {31'b0, serial_out}, 32'h0);
    repeat (12) tick();
    chk("mid_data_low", {31'b0, serial_out}, 32'h0);
    rst = 1'b0;
    tick();
    chk("mid_rst_line_high", {31'b0, serial_out}, 32'h1);
    chk("mid_rst_rdata", rdata, 32'h0);
    rst = 1'b1;
    repeat (10) tick();
    chk("mid_rst_stays_high", {31'b0, serial_out}, 32'h1);
    rd(A_ST);
    chk("mid_rst_status", rdata, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
